// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (core, aux) for a single unified memory
// port. Requests are sampled only in IDLE. The winner owns the memory for
// exactly one ACC_* cycle, and read data is routed back the cycle after that.
// Optional build macro: ARB_ROUND_ROBIN_EN (ties go to the requester that was
// not granted last). When it is undefined, core has fixed priority and a
// MAX_WAIT starvation counter guarantees that aux eventually wins.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC_CORE = 2'd1,
        ACC_AUX  = 2'd2
    } state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_AUX  = 1'b1;

    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic                mem_we_q,     mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic                core_gnt_q,   core_gnt_d;
    logic                aux_gnt_q,    aux_gnt_d;
    logic                rd_pending_q, rd_pending_d;
    logic                rd_owner_q,   rd_owner_d;
    logic                last_owner_q, last_owner_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]   aux_rdata_q,  aux_rdata_d;

    logic                grant_core_s;
    logic                grant_aux_s;
    logic                core_rvalid_s;
    logic                aux_rvalid_s;

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];
    logic [7:0]          wait_cnt_q,   wait_cnt_d;
`endif

    // Arbitration: only in IDLE; single requester wins outright, ties per priority rule.
    always_comb begin
        grant_core_s = 1'b0;
        grant_aux_s  = 1'b0;
        if (state_q == IDLE) begin
            if (core_req && aux_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_owner_q == OWN_CORE) begin
                    grant_aux_s = 1'b1;
                end else begin
                    grant_core_s = 1'b1;
                end
`else
                if (wait_cnt_q >= MAX_WAIT_C) begin
                    grant_aux_s = 1'b1;
                end else begin
                    grant_core_s = 1'b1;
                end
`endif
            end else if (core_req) begin
                grant_core_s = 1'b1;
            end else if (aux_req) begin
                grant_aux_s = 1'b1;
            end else begin
                grant_core_s = 1'b0;
                grant_aux_s  = 1'b0;
            end
        end else begin
            grant_core_s = 1'b0;
            grant_aux_s  = 1'b0;
        end
    end

    // Next state: an access lasts one cycle and always falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (grant_core_s) begin
                    state_d = ACC_CORE;
                end else if (grant_aux_s) begin
                    state_d = ACC_AUX;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC_CORE: state_d = IDLE;
            ACC_AUX:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Memory drive: load the winner's access for the ACC cycle; outside it only mem_we drops.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        core_gnt_d  = grant_core_s;
        aux_gnt_d   = grant_aux_s;
        if (grant_core_s) begin
            mem_addr_d  = core_addr;
            mem_wdata_d = core_wdata;
            mem_we_d    = core_we;
        end else if (grant_aux_s) begin
            mem_addr_d  = aux_addr;
            mem_wdata_d = aux_wdata;
            mem_we_d    = aux_we;
        end else begin
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
            mem_we_d    = 1'b0;
        end
    end

    // Read tracking: remember who owned the ACC cycle and whether it was a read.
    always_comb begin
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;
        if (state_q == ACC_CORE) begin
            rd_pending_d = ~mem_we_q;
            rd_owner_d   = OWN_CORE;
        end else if (state_q == ACC_AUX) begin
            rd_pending_d = ~mem_we_q;
            rd_owner_d   = OWN_AUX;
        end else begin
            rd_pending_d = 1'b0;
            rd_owner_d   = rd_owner_q;
        end
    end

    // Last owner follows every grant (it only steers ties in round-robin builds).
    always_comb begin
        last_owner_d = last_owner_q;
        if (grant_core_s) begin
            last_owner_d = OWN_CORE;
        end else if (grant_aux_s) begin
            last_owner_d = OWN_AUX;
        end else begin
            last_owner_d = last_owner_q;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Starvation counter: counts aux losses, cleared when aux is finally served.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_aux_s) begin
            wait_cnt_d = 8'd0;
        end else if (grant_core_s && aux_req) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end
`endif

    assign core_rvalid_s = rd_pending_q & (rd_owner_q == OWN_CORE);
    assign aux_rvalid_s  = rd_pending_q & (rd_owner_q == OWN_AUX);

    // Read-data capture: each side keeps the last word it received.
    always_comb begin
        core_rdata_d = core_rdata_q;
        aux_rdata_d  = aux_rdata_q;
        if (core_rvalid_s) begin
            core_rdata_d = mem_rdata;
        end else if (aux_rvalid_s) begin
            aux_rdata_d = mem_rdata;
        end else begin
            core_rdata_d = core_rdata_q;
            aux_rdata_d  = aux_rdata_q;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= {DATA_W{1'b0}};
            core_gnt_q   <= 1'b0;
            aux_gnt_q    <= 1'b0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWN_CORE;
            last_owner_q <= OWN_AUX;
            core_rdata_q <= {DATA_W{1'b0}};
            aux_rdata_q  <= {DATA_W{1'b0}};
`ifndef ARB_ROUND_ROBIN_EN
            wait_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            core_gnt_q   <= core_gnt_d;
            aux_gnt_q    <= aux_gnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            last_owner_q <= last_owner_d;
            core_rdata_q <= core_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
`ifndef ARB_ROUND_ROBIN_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign core_gnt    = core_gnt_q;
    assign aux_gnt     = aux_gnt_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign core_rvalid = core_rvalid_s;
    assign aux_rvalid  = aux_rvalid_s;
    // The memory returns data in the rvalid cycle itself, so it is passed through then.
    assign core_rdata  = core_rvalid_s ? mem_rdata : core_rdata_q;
    assign aux_rdata   = aux_rvalid_s  ? mem_rdata : aux_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level reference model compared every
// cycle, plus hand-computed checks for the main scenarios.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          core_req, core_we, aux_req, aux_we;
    logic [AW-1:0] core_addr, aux_addr;
    logic [DW-1:0] core_wdata, aux_wdata;
    logic          core_gnt, core_rvalid, aux_gnt, aux_rvalid;
    logic [DW-1:0] core_rdata, aux_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
        .aux_rdata(aux_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory attached to the DUT: synchronous read, data one cycle after the address.
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hCAFE0020;
        forever begin
            @(posedge clk);
            mem_rdata <= mem[mem_addr[7:0]];
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // Reference model: which access occupies the memory this cycle and what reply is due.
    bit            m_busy, m_own, m_we;        // own: 0 = core, 1 = aux
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_rv, m_rv_own;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] m_hold [0:1];
    int            m_lost;                     // consecutive aux losses
    bit            m_last;
    logic [DW-1:0] ref_mem [0:255];

    task automatic model_step();
        bit any, win;
        if (m_busy && m_we) ref_mem[m_addr[7:0]] = m_wdata;
        if (reset) begin
            m_busy = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_rv = 1'b0; m_hold[0] = '0; m_hold[1] = '0;
            m_lost = 0; m_last = 1'b1;
        end else begin
            if (m_rv) m_hold[m_rv_own] = m_rv_data;
            if (m_busy) begin
                m_rv = !m_we; m_rv_own = m_own; m_rv_data = ref_mem[m_addr[7:0]];
                m_busy = 1'b0; m_we = 1'b0;
            end else begin
                m_rv = 1'b0;
                any = core_req || aux_req;
                if (core_req && aux_req) win = RR ? !m_last : (m_lost == MW);
                else win = aux_req;
                if (any) begin
                    if (win) m_lost = 0;
                    else if (aux_req) m_lost = m_lost + 1;
                    m_busy = 1'b1; m_own = win; m_last = win;
                    m_addr  = win ? aux_addr  : core_addr;
                    m_we    = win ? aux_we    : core_we;
                    m_wdata = win ? aux_wdata : core_wdata;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("core_gnt",    64'(core_gnt),    64'(m_busy && !m_own));
                chk("aux_gnt",     64'(aux_gnt),     64'(m_busy && m_own));
                chk("mem_we",      64'(mem_we),      64'(m_busy && m_we));
                chk("mem_addr",    64'(mem_addr),    64'(m_addr));
                chk("mem_wdata",   64'(mem_wdata),   64'(m_wdata));
                chk("core_rvalid", 64'(core_rvalid), 64'(m_rv && !m_rv_own));
                chk("aux_rvalid",  64'(aux_rvalid),  64'(m_rv && m_rv_own));
                chk("core_rdata",  64'(core_rdata),  64'((m_rv && !m_rv_own) ? m_rv_data : m_hold[0]));
                chk("aux_rdata",   64'(aux_rdata),   64'((m_rv && m_rv_own) ? m_rv_data : m_hold[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_aux(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
    endtask

    logic [11:0] seq;
    int          n_gnt;
    int          gnt_t [0:11];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h20] = 32'hCAFE0020;
        reset = 1'b1;
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_aux(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_core_gnt",   64'(core_gnt),   64'h0);
        chk("rst_mem_addr",   64'(mem_addr),   64'h0);
        chk("rst_core_rdata", 64'(core_rdata), 64'h0);
        reset = 1'b0;

        // Core read alone.
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        chk("cr_gnt",  64'(core_gnt), 64'h1);
        chk("cr_addr", 64'(mem_addr), 64'h10);
        set_core(1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        chk("cr_rvalid", 64'(core_rvalid), 64'h1);
        chk("cr_rdata",  64'(core_rdata),  64'hDEADBEEF);
        chk("cr_aux_rv", 64'(aux_rvalid),  64'h0);
        tick();

        // Aux write alone.
        set_aux(1'b1, 1'b1, 32'h40, 32'h1234);
        tick();
        chk("aw_gnt",   64'(aux_gnt),   64'h1);
        chk("aw_we",    64'(mem_we),    64'h1);
        chk("aw_wdata", 64'(mem_wdata), 64'h1234);
        set_aux(1'b0, 1'b0, 32'h40, 32'h1234);
        tick();
        chk("aw_we_off", 64'(mem_we),     64'h0);
        chk("aw_no_rv",  64'(aux_rvalid), 64'h0);
        chk("aw_mem",    64'(mem[8'h40]), 64'h1234);

        // Core write then read back.
        set_core(1'b1, 1'b1, 32'h30, 32'hA5A55A5A);
        tick();
        set_core(1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        tick();
        set_core(1'b0, 1'b0, 32'h30, 32'h0);
        tick();
        chk("cw_readback", 64'(core_rdata), 64'hA5A55A5A);

        // Contention from reset: both requesters hold read requests.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        set_aux(1'b1, 1'b0, 32'h20, 32'h0);
        seq = 12'h0;
        n_gnt = 0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if ((core_gnt || aux_gnt) && n_gnt < 12) begin
                seq[n_gnt] = aux_gnt;
                gnt_t[n_gnt] = t;
                n_gnt++;
            end
        end
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_aux(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("arb_count", 64'(n_gnt), 64'd12);
        chk("arb_order", 64'(seq), RR ? 64'hAAA : 64'h210);
        chk("arb_t0", 64'(gnt_t[0]), 64'd1);
        chk("arb_t3", 64'(gnt_t[3]), 64'd7);
        tick();

        // Reset landing on the ACC_CORE cycle of a read.
        set_core(1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        chk("rr_gnt", 64'(core_gnt), 64'h1);
        reset = 1'b1;
        set_core(1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        chk("rr_no_rv", 64'(core_rvalid), 64'h0);
        chk("rr_gnt0",  64'(core_gnt),    64'h0);
        chk("rr_addr0", 64'(mem_addr),    64'h0);
        chk("rr_rdata", 64'(core_rdata),  64'h0);
        reset = 1'b0;
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        chk("rr_fresh_gnt", 64'(core_gnt), 64'h1);
        set_core(1'b0, 1'b0, 32'h10, 32'h0);
        tick();

        // Interleaved: aux request rises in the core's rvalid cycle.
        set_core(1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        set_core(1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        chk("il_core_rv",    64'(core_rvalid), 64'h1);
        chk("il_core_rdata", 64'(core_rdata),  64'hCAFE0020);
        set_aux(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        chk("il_aux_gnt",  64'(aux_gnt),  64'h1);
        chk("il_core_gnt", 64'(core_gnt), 64'h0);
        set_aux(1'b0, 1'b0, 32'h40, 32'h0);
        tick();
        chk("il_aux_rv",     64'(aux_rvalid),  64'h1);
        chk("il_aux_rdata",  64'(aux_rdata),   64'h1234);
        chk("il_core_hold",  64'(core_rdata),  64'hCAFE0020);
        chk("il_core_rv0",   64'(core_rvalid), 64'h0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
